// File: rtl/alu_mux.sv
// ALU operand-B source selector: RD2 or ImmExt onto SrcB,
// plus a registered copy for pipelined or debug consumers.
module alu_mux #(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] RD2,
    input  logic [WIDTH-1:0] ImmExt,
    input  logic             ALUSrc,
    output logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] SrcB_q
);

    logic [WIDTH-1:0] sel_b;

    assign sel_b = ALUSrc ? ImmExt : RD2;

    always_ff @(posedge clk) begin
        if (!rst_n) SrcB_q <= '0;
        else        SrcB_q <= sel_b;
    end

    // Combinational path stays clock-free unless the registered view is asked for
    generate
        if (REG_OUT) begin : g_reg
            assign SrcB = SrcB_q;
        end else begin : g_comb
            assign SrcB = sel_b;
        end
    endgenerate

endmodule

// File: tb/tb_alu_mux.sv
// Bench for alu_mux: combinational and registered instances
// checked against a behavioural operand-select model.
module tb_alu_mux;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd2 = '0;
    logic [31:0] imm = '0;
    logic        alusrc = 1'b0;
    logic [31:0] srcb0, srcb_q0;
    logic [31:0] srcb1, srcb_q1;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq;
    bit          cmp_en = 1'b0;

    alu_mux #(.WIDTH(32), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .RD2(rd2), .ImmExt(imm),
        .ALUSrc(alusrc), .SrcB(srcb0), .SrcB_q(srcb_q0)
    );

    alu_mux #(.WIDTH(32), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .RD2(rd2), .ImmExt(imm),
        .ALUSrc(alusrc), .SrcB(srcb1), .SrcB_q(srcb_q1)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [31:0] pick(input logic s,
                                         input logic [31:0] r,
                                         input logic [31:0] i);
        return s ? i : r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference register: holds what was selected at the last edge
    always @(posedge clk) mq <= rst_n ? pick(alusrc, rd2, imm) : 32'h0;

    always @(negedge clk) begin
        #1;
        chk("comb_model", srcb0, pick(alusrc, rd2, imm));
        if (cmp_en) begin
            chk("q_model", srcb_q0, mq);
            chk("q_model_r1", srcb_q1, mq);
            chk("regout_model", srcb1, mq);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    logic [31:0] vr [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h0F0F_0F0F, 32'h1357_9BDF,
                            32'h0000_0000, 32'hCAFE_F00D};
    logic [31:0] vi [8] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h8000_0000,
                            32'h7FFF_FFFF, 32'hF0F0_F0F0, 32'h2468_ACE0,
                            32'hFFFF_FFFF, 32'h0BAD_BEEF};

    initial begin
        // Clock idle: pure combinational checks
        rd2 = 32'hAAAA_AAAA; imm = 32'h1234_5678; alusrc = 1'b0;
        #10 chk("s1_rd2", srcb0, 32'hAAAA_AAAA);
        alusrc = 1'b1;
        #10 chk("s2_imm", srcb0, 32'h1234_5678);
        rd2 = 32'hDEAD_BEEF; imm = 32'hBEEF_DEAD; alusrc = 1'b0;
        #10 chk("s3_rd2", srcb0, 32'hDEAD_BEEF);
        alusrc = 1'b1;
        #10 chk("s3_imm", srcb0, 32'hBEEF_DEAD);
        rst_n = 1'b0; rd2 = 32'hFFFF_FFFF; imm = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            alusrc = k[0];
            #10 chk("s4_toggle", srcb0, k[0] ? 32'h0 : 32'hFFFF_FFFF);
        end

        // Clock running, reset held for two edges
        clk_en = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        next_cycle();
        cmp_en = 1'b1;
        chk("s5_rst_q", srcb_q0, 32'h0);
        chk("s5_rst_regout", srcb1, 32'h0);

        rst_n = 1'b1; alusrc = 1'b1; imm = 32'h8000_0001; rd2 = 32'h0000_1234;
        next_cycle();
        chk("s5_load_imm", srcb_q0, 32'h8000_0001);
        alusrc = 1'b0;
        #1 chk("s5_hold", srcb_q0, 32'h8000_0001);
        chk("s5_comb_now", srcb0, 32'h0000_1234);
        next_cycle();
        chk("s5_load_rd2", srcb_q0, 32'h0000_1234);

        // Registered output instance
        rd2 = 32'h0000_0005; alusrc = 1'b0;
        #1 chk("s6_before_edge", srcb1, 32'h0000_1234);
        next_cycle();
        chk("s6_after_edge", srcb1, 32'h0000_0005);
        rst_n = 1'b0;
        next_cycle();
        chk("s6_rst_regout", srcb1, 32'h0);
        chk("s6_comb_in_rst", srcb0, 32'h0000_0005);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            rd2 = vr[k % 8]; imm = vi[k % 8]; alusrc = k[1];
            if (k == 11) rst_n = 1'b0;
            if (k == 12) rst_n = 1'b1;
            next_cycle();
        end

        cmp_en = 1'b0;
        #20;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mux.md
# alu_mux

ALU operand-B source selector for the single-cycle RISC-V datapath. Chooses between register-file read port 2 (`RD2`) and the sign-extended immediate (`ImmExt`) under control of `ALUSrc`, and drives the ALU's `SrcB` input. The select path is purely combinational. A registered copy of the selected operand is also provided for pipelined or debug consumers, clocked by the single datapath clock.

## Interface
Parameters:
- `WIDTH`, default 32, data width of all operand ports.
- `REG_OUT`, default 0. When 0, `SrcB` is combinational. When 1, `SrcB` is driven from the register `SrcB_q`.

Ports:
- `clk`  input  1  datapath clock; rising edge active.
- `rst_n`  input  1  reset. One clock; reset is synchronous and active-low.
- `RD2`  input  WIDTH  register-file read data 2.
- `ImmExt`  input  WIDTH  extended immediate from the immediate generator.
- `ALUSrc`  input  1  operand select: 0 selects `RD2`, 1 selects `ImmExt`.
- `SrcB`  output  WIDTH  ALU operand B.
- `SrcB_q`  output  WIDTH  registered copy of the selected operand.

## Operation
- Selection `sel_b`:
  - `ALUSrc`=0: `sel_b = RD2`.
  - `ALUSrc`=1: `sel_b = ImmExt`.
  - All WIDTH bits are passed unmodified: no sign or zero extension, no truncation, no arithmetic.
- `ALUSrc` of X/Z is not a legal input. The implementation uses a plain 2:1 mux, and any resolution of X/Z is acceptable.
- With `REG_OUT`=0 (default), `SrcB = sel_b` combinationally. It depends only on the current `RD2`, `ImmExt` and `ALUSrc`. It is independent of `clk` and `rst_n`, and valid with no clock running.
- With `REG_OUT`=1, `SrcB = SrcB_q`.
- `SrcB_q` behaviour on each rising `clk` edge:
  - If `rst_n`=0, `SrcB_q` loads 0.
  - Otherwise, `SrcB_q` loads `sel_b`.
- The block has no state machine and no handshake.

## Timing
- `REG_OUT`=0:
  - `SrcB` has zero-cycle latency: it settles within the same delta or combinational path after any input change.
  - Reset has no effect on `SrcB`.
- `SrcB_q`:
  - Latency is 1 cycle: it reflects `sel_b` sampled at the previous rising edge.
  - Reset value is 0, taking effect at the first rising edge with `rst_n` low.
  - Before the first clock edge, its value is undefined.
- Reset asserted mid-operation: at the next edge `SrcB_q` becomes 0 regardless of inputs. With `REG_OUT`=0, combinational `SrcB` continues to track its inputs.
- Input changes between clock edges do not affect `SrcB_q` until the next edge.
- Simultaneous change of `ALUSrc` and the data inputs: `SrcB` reflects the new select applied to the new data. No glitch-free guarantee is required.

## Test plan
All scenarios use `REG_OUT`=0 unless stated. No clock is needed for scenarios 1–4.
1. `RD2`=0xAAAAAAAA, `ImmExt`=0x12345678, `ALUSrc`=0, wait 10 ns -> `SrcB`=0xAAAAAAAA.
2. Same data, `ALUSrc`=1, wait 10 ns -> `SrcB`=0x12345678.
3. `RD2`=0xDEADBEEF, `ImmExt`=0xBEEFDEAD, `ALUSrc`=0, wait 10 ns -> `SrcB`=0xDEADBEEF. Then `ALUSrc`=1 -> `SrcB`=0xBEEFDEAD.
4. Toggle `ALUSrc` while holding `rst_n`=0 and `clk` idle, with `RD2`=0xFFFFFFFF and `ImmExt`=0x00000000 -> `SrcB` alternates 0xFFFFFFFF / 0x00000000. Reset does not affect it.
5. Clock running, `rst_n`=0 for 2 edges -> `SrcB_q`=0. Release reset with `ALUSrc`=1 and `ImmExt`=0x80000001 -> `SrcB_q`=0x80000001 after the next edge. Change `ALUSrc` to 0 between edges -> `SrcB_q` stays unchanged until that edge.
6. `REG_OUT`=1, `RD2`=0x00000005, `ALUSrc`=0 -> `SrcB` equals 0x00000005 one edge after the input is applied, and 0 while `rst_n` is low at an edge.
